// File: rtl/tdm_demux_rx.sv
// Receive side of the two-channel TDM link: splits the shared A/B bus into paired A and B words.
// Optional macro TDM_TIMEOUT_EN adds a gap timeout while waiting for the B beat.
module tdm_demux_rx #(
    parameter int unsigned Length = 1,
    parameter int unsigned MaxGap = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [Length-1:0] d_i,
    input  logic              valid_i,
    input  logic              sel_i,
    output logic [Length-1:0] a_o,
    output logic [Length-1:0] b_o,
    output logic              pair_valid_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [3:0]        err_cnt_o
);

    if (MaxGap < 1 || MaxGap > 255) begin : g_maxgap_check
        $error("tdm_demux_rx: MaxGap must be within 1..255");
    end

    typedef enum logic {StWaitA, StWaitB} state_e;

    state_e            state;
    logic [Length-1:0] a_hold;
    logic              take_a;
    logic              take_b;
    logic              frame_err;
    logic              timeout;
    logic              err_evt;

`ifdef TDM_TIMEOUT_EN
    localparam logic [7:0] GapLimit = 8'(MaxGap);
    logic [7:0] gap;

    // A valid beat never times out, so a B landing on the limit cycle still completes the pair.
    assign timeout = (state == StWaitB) && !valid_i && ((gap + 8'd1) == GapLimit);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        take_a    = valid_i && !sel_i;
        take_b    = valid_i && sel_i && (state == StWaitB);
        frame_err = valid_i && ((sel_i && (state == StWaitA)) || (!sel_i && (state == StWaitB)));
        err_evt   = frame_err || timeout;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= StWaitA;
            a_hold       <= '0;
            a_o          <= '0;
            b_o          <= '0;
            pair_valid_o <= 1'b0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
            err_cnt_o    <= 4'd0;
`ifdef TDM_TIMEOUT_EN
            gap          <= 8'd0;
`endif
        end else begin
            pair_valid_o <= take_b;
            err_o        <= err_evt;
            if (err_evt && (err_cnt_o != 4'hF)) begin
                err_cnt_o <= err_cnt_o + 4'd1;
            end

            unique case (state)
                StWaitA: begin
                    if (take_a) begin
                        a_hold <= d_i;
                        state  <= StWaitB;
                        busy_o <= 1'b1;
                    end
                end
                StWaitB: begin
                    if (take_b) begin
                        a_o    <= a_hold;
                        b_o    <= d_i;
                        state  <= StWaitA;
                        busy_o <= 1'b0;
                    end else if (take_a) begin
                        // Repeated A: resync to the newest word.
                        a_hold <= d_i;
                    end else if (timeout) begin
                        a_hold <= '0;
                        state  <= StWaitA;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= StWaitA;
                    busy_o <= 1'b0;
                end
            endcase

`ifdef TDM_TIMEOUT_EN
            if (valid_i || (state == StWaitA) || timeout) begin
                gap <= 8'd0;
            end else begin
                gap <= gap + 8'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Self-checking bench for tdm_demux_rx: directed literal checks plus randomized traffic
// compared every cycle against a pair-level reference model.
module tb_tdm_demux_rx;

    localparam int unsigned W      = 4;
    localparam int unsigned MAXGAP = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] d     = '0;
    logic         valid = 1'b0;
    logic         sel   = 1'b0;

    logic [W-1:0] a_o;
    logic [W-1:0] b_o;
    logic         pair_valid_o;
    logic         err_o;
    logic         busy_o;
    logic [3:0]   err_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    tdm_demux_rx #(
        .Length (W),
        .MaxGap (MAXGAP)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .d_i          (d),
        .valid_i      (valid),
        .sel_i        (sel),
        .a_o          (a_o),
        .b_o          (b_o),
        .pair_valid_o (pair_valid_o),
        .err_o        (err_o),
        .busy_o       (busy_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: tracks "A seen, B owed" plus the expected visible outputs.
    int m_a = 0, m_b = 0, m_hold = 0, m_cnt = 0, m_gap = 0;
    bit m_busy = 0, m_pv = 0, m_err = 0;

    always @(posedge clk or negedge rst_n) begin
        bit bad;
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_hold = 0; m_cnt = 0; m_gap = 0;
            m_busy = 0; m_pv = 0; m_err = 0;
        end else begin
            bad  = 0;
            m_pv = 0;
            if (valid) begin
                m_gap = 0;
                if (!sel) begin
                    if (m_busy) bad = 1;
                    m_hold = int'(d);
                    m_busy = 1;
                end else if (m_busy) begin
                    m_a    = m_hold;
                    m_b    = int'(d);
                    m_pv   = 1;
                    m_busy = 0;
                end else begin
                    bad = 1;
                end
            end else if (m_busy) begin
`ifdef TDM_TIMEOUT_EN
                m_gap = m_gap + 1;
                if (m_gap >= MAXGAP) begin
                    bad    = 1;
                    m_busy = 0;
                    m_gap  = 0;
                end
`endif
            end
            m_err = bad;
            if (bad && m_cnt < 15) m_cnt = m_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model a_o", int'(a_o), m_a);
        chk("model b_o", int'(b_o), m_b);
        chk("model pair_valid_o", int'(pair_valid_o), int'(m_pv));
        chk("model err_o", int'(err_o), int'(m_err));
        chk("model busy_o", int'(busy_o), int'(m_busy));
        chk("model err_cnt_o", int'(err_cnt_o), m_cnt);
        chk("pv/err exclusive", int'(pair_valid_o && err_o), 0);
    end

    // Inputs change 1 time unit after each rising edge; each call covers one cycle.
    task automatic beat(input bit v, input bit s, input logic [W-1:0] dv);
        valid = v;
        sel   = s;
        d     = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, '0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset a_o", int'(a_o), 0);
        chk("reset busy_o", int'(busy_o), 0);
        chk("reset err_cnt_o", int'(err_cnt_o), 0);
        rst_n = 1'b1;

        // Simple pair
        beat(1, 0, 4'h3);
        chk("pair1 busy", int'(busy_o), 1);
        beat(1, 1, 4'hC);
        chk("pair1 pv", int'(pair_valid_o), 1);
        chk("pair1 a", int'(a_o), 3);
        chk("pair1 b", int'(b_o), 12);
        chk("pair1 cnt", int'(err_cnt_o), 0);
        idle();
        chk("pair1 pv drop", int'(pair_valid_o), 0);

        // Back-to-back pairs
        beat(1, 0, 4'h5);
        chk("b2b busy1", int'(busy_o), 1);
        beat(1, 1, 4'h6);
        chk("b2b pv1", int'(pair_valid_o), 1);
        chk("b2b busy2", int'(busy_o), 0);
        beat(1, 0, 4'h7);
        chk("b2b pv gap", int'(pair_valid_o), 0);
        chk("b2b busy3", int'(busy_o), 1);
        chk("b2b hold a", int'(a_o), 5);
        beat(1, 1, 4'h8);
        chk("b2b pv2", int'(pair_valid_o), 1);
        chk("b2b a", int'(a_o), 7);
        chk("b2b b", int'(b_o), 8);
        idle();

        // B without A
        reset_dut();
        beat(1, 1, 4'h9);
        chk("orphanB err", int'(err_o), 1);
        chk("orphanB a", int'(a_o), 0);
        chk("orphanB b", int'(b_o), 0);
        chk("orphanB cnt", int'(err_cnt_o), 1);
        chk("orphanB busy", int'(busy_o), 0);

        // Repeated A resyncs to newest
        beat(1, 0, 4'h1);
        chk("repA no err", int'(err_o), 0);
        beat(1, 0, 4'h2);
        chk("repA err", int'(err_o), 1);
        chk("repA busy", int'(busy_o), 1);
        beat(1, 1, 4'h4);
        chk("repA pv", int'(pair_valid_o), 1);
        chk("repA err clr", int'(err_o), 0);
        chk("repA a", int'(a_o), 2);
        chk("repA b", int'(b_o), 4);
        chk("repA cnt", int'(err_cnt_o), 2);

        // Saturating error counter
        reset_dut();
        for (int i = 0; i < 17; i++) beat(1, 1, 4'(i));
        chk("sat cnt", int'(err_cnt_o), 15);
        idle();
        chk("sat cnt hold", int'(err_cnt_o), 15);

`ifdef TDM_TIMEOUT_EN
        reset_dut();
        beat(1, 0, 4'hA);
        for (int i = 0; i < 15; i++) idle();
        chk("to pre err", int'(err_o), 0);
        chk("to pre busy", int'(busy_o), 1);
        idle();
        chk("to err", int'(err_o), 1);
        chk("to busy", int'(busy_o), 0);
        chk("to cnt", int'(err_cnt_o), 1);
        beat(1, 1, 4'hB);
        chk("to lateB err", int'(err_o), 1);
        chk("to lateB pv", int'(pair_valid_o), 0);
        chk("to lateB b", int'(b_o), 0);
        chk("to lateB cnt", int'(err_cnt_o), 2);
        beat(1, 0, 4'h5);
        for (int i = 0; i < 15; i++) idle();
        beat(1, 1, 4'h6);
        chk("to edge pv", int'(pair_valid_o), 1);
        chk("to edge err", int'(err_o), 0);
        chk("to edge a", int'(a_o), 5);
        chk("to edge b", int'(b_o), 6);
`else
        reset_dut();
        beat(1, 0, 4'hA);
        for (int i = 0; i < 40; i++) idle();
        chk("nto busy", int'(busy_o), 1);
        chk("nto err", int'(err_cnt_o), 0);
        beat(1, 1, 4'hB);
        chk("nto pv", int'(pair_valid_o), 1);
        chk("nto a", int'(a_o), 10);
        chk("nto b", int'(b_o), 11);
`endif

        // Asynchronous reset while busy
        beat(1, 0, 4'hD);
        beat(1, 1, 4'hE);
        beat(1, 0, 4'hF);
        chk("arst pre busy", int'(busy_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst busy", int'(busy_o), 0);
        chk("arst a", int'(a_o), 0);
        chk("arst b", int'(b_o), 0);
        chk("arst cnt", int'(err_cnt_o), 0);
        chk("arst pv", int'(pair_valid_o), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic, mostly well-formed with occasional errors, idles and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            beat(($urandom_range(99) < 70), ($urandom_range(99) < 50), 4'($urandom));
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receive end of the two-channel time-division link. The transmit side drives one shared bus through the 2:1 Mux, toggling the select between channel A and channel B.
- This block demultiplexes that single bus back into separate, simultaneously updated A and B registers.
- It enforces A-then-B beat ordering and reports framing errors.
- It sits between the shared bus and downstream consumers such as display and compare logic.

Parameters:
- Length, 1, data width of each channel and of the shared bus.
- MaxGap, 16, cycles allowed in WAIT_B without a valid beat before timeout. Used only with TDM_TIMEOUT_EN. Legal range 1..255.

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- d_i  input  Length  shared bus data.
- valid_i  input  1  d_i/sel_i carry a beat this cycle.
- sel_i  input  1  channel tag; 0 = channel A, 1 = channel B (same encoding as the Mux select).
- a_o  output  Length  last completed channel-A word.
- b_o  output  Length  last completed channel-B word.
- pair_valid_o  output  1  one-cycle pulse: a_o/b_o just updated as a pair.
- err_o  output  1  one-cycle pulse: framing error or timeout.
- busy_o  output  1  high while in WAIT_B (A captured, B pending).
- err_cnt_o  output  4  count of error events, saturating at 15.

Behaviour:
- Reset (rst_n_i low, asynchronous, takes effect immediately):
  - state = WAIT_A.
  - a_o, b_o, internal a_hold = 0.
  - pair_valid_o, err_o, busy_o = 0; err_cnt_o = 0; gap counter = 0.
  - Reset mid-pair discards a_hold; no pair_valid_o is produced.
- All outputs are registered; no combinational path from inputs to outputs.
- Beats with valid_i = 0 are ignored, except for timeout counting.
- WAIT_A:
  - valid_i & sel_i = 0: a_hold <= d_i; go to WAIT_B.
  - valid_i & sel_i = 1 (B without A): err_o pulses next cycle; beat discarded; stay in WAIT_A.
- WAIT_B:
  - valid_i & sel_i = 1: a_o <= a_hold and b_o <= d_i in the same edge; pair_valid_o pulses the following cycle (1-cycle latency from the accepted B beat); go to WAIT_A.
  - valid_i & sel_i = 0 (A repeated): err_o pulses; a_hold <= new d_i (resync to newest A); stay in WAIT_B.
- busy_o is asserted the cycle after A is accepted and deasserts the cycle after B is accepted.
- a_o and b_o hold their values between pairs. They never update individually.
- Back-to-back pairs (A, B, A, B on consecutive cycles) are accepted with no bubbles; pair_valid_o pulses every second cycle.
- err_cnt_o increments by 1 per err_o pulse and saturates at 15. It has no wrap-around; only reset clears it.
- pair_valid_o and err_o are never high in the same cycle.

Optional Feature:
- Macro: TDM_TIMEOUT_EN.
- Defined:
  - An 8-bit gap counter clears on entry to WAIT_B and on every valid beat.
  - It increments each WAIT_B cycle with valid_i = 0.
  - When it reaches MaxGap: err_o pulses, err_cnt_o increments, a_hold is discarded, state returns to WAIT_A.
  - A valid B beat arriving in the same cycle the counter reaches MaxGap wins: the pair completes and no timeout occurs.
- Undefined:
  - No counter logic is synthesized.
  - WAIT_B waits indefinitely for B.

Test Plan (Length = 4):
- Reset release, then A = 4'h3 followed next cycle by B = 4'hC -> a_o = 3, b_o = C, pair_valid_o high exactly one cycle after B, err_cnt_o = 0.
- Consecutive A5, B6, A7, B8 -> pair_valid_o pulses twice, 2 cycles apart; final a_o = 7, b_o = 8; busy_o toggles every cycle.
- B = 4'h9 with no prior A -> err_o pulse, a_o/b_o unchanged (0), err_cnt_o = 1, state WAIT_A.
- A1, A2, B4 -> one err_o after the second A; then a_o = 2, b_o = 4, pair_valid_o pulse.
- 17 sel_i = 1 beats from reset -> err_cnt_o counts to 15 and stays at 15.
- With TDM_TIMEOUT_EN and MaxGap = 16: A = 4'hA, then 16 idle cycles -> err_o pulse; a subsequent B = 4'hB is then flagged as an error with no pair. B arriving on idle cycle 16 -> pair completes, no err_o. Rst_n_i low while busy_o = 1 -> all outputs 0 immediately.
